// File: rtl/sig_pkg.sv
// sig_pkg: shared FSM state type, default MISR constants and readout word-count helper
package sig_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [81:0] DEF_POLY = 82'h2_0000_0000_0000_0000_0023;
  localparam logic [81:0] DEF_SEED = '0;
  function automatic int num_words(int y_w, int rd_w);
    return (y_w + rd_w - 1) / rd_w;
  endfunction
endpackage

// File: rtl/response_signature_compactor_if.sv
// response_signature_compactor_if: signature readout valid/ready port (rd_valid, rd_ready, rd_data, rd_last); master drives words, slave accepts
interface response_signature_compactor_if #(
  parameter int RD_W = 32
);
  logic            rd_valid;
  logic            rd_ready;
  logic            rd_last;
  logic [RD_W-1:0] rd_data;
  modport master (output rd_valid, rd_data, rd_last, input rd_ready);
  modport slave (input rd_valid, rd_data, rd_last, output rd_ready);
endinterface

// File: rtl/misr_core.sv
// misr_core: multiple-input signature register; clk/rst_n, load seeds q, en folds d into q, nxt is the value q takes on the next enabled edge
module misr_core
  import sig_pkg::*;
#(
  parameter int W = 82,
  parameter logic [W-1:0] POLY = DEF_POLY
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] seed,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] nxt
);
  assign nxt = {q[W-2:0], 1'b0} ^ (q[W-1] ? POLY : '0) ^ d;
  always_ff @(posedge clk)
    if (!rst_n || load) q <= seed;
    else if (en) q <= nxt;
endmodule

// File: rtl/response_signature_compactor.sv
// response_signature_compactor: compacts y into a MISR for CYCLES clocks after start, compares with golden_sig (done/match), then drains the signature LSB word first on rd; busy marks RUN/DRAIN, sample_cnt counts samples
module response_signature_compactor
  import sig_pkg::*;
#(
  parameter int Y_W = 82,
  parameter int CYCLES = 25,
  parameter logic [Y_W-1:0] POLY = DEF_POLY,
  parameter logic [Y_W-1:0] SEED = DEF_SEED,
  parameter int RD_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [Y_W-1:0]        y,
  input  logic [Y_W-1:0]        golden_sig,
  output logic                  busy,
  output logic                  done,
  output logic                  match,
  output logic [15:0]           sample_cnt,
  response_signature_compactor_if.master rd
);
  localparam int NW = num_words(Y_W, RD_W);
  localparam int IW = $clog2(NW + 1);
  state_t             state;
  logic [Y_W-1:0]     q;
  logic [Y_W-1:0]     nxt;
  logic [NW*RD_W-1:0] cur;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      nidx;
  logic               last_sample;
  assign busy        = state != IDLE;
  assign cur         = (NW*RD_W)'(q);
  assign nidx        = idx + IW'(1);
  assign last_sample = sample_cnt + 16'd1 == 16'(CYCLES);
  misr_core #(.W(Y_W), .POLY(POLY)) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (state == IDLE && start),
    .en   (state == RUN),
    .seed (SEED),
    .d    (y),
    .q    (q),
    .nxt  (nxt)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      done        <= 1'b0;
      match       <= 1'b0;
      idx         <= '0;
      rd.rd_valid <= 1'b0;
      rd.rd_data  <= '0;
      rd.rd_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state      <= RUN;
          sample_cnt <= '0;
          done       <= 1'b0;
          match      <= 1'b0;
        end
        RUN: begin
          sample_cnt <= sample_cnt + 16'd1;
          if (last_sample) begin
            state       <= DRAIN;
            match       <= nxt == golden_sig;
            idx         <= '0;
            rd.rd_valid <= 1'b1;
            rd.rd_data  <= RD_W'(nxt);
            rd.rd_last  <= NW == 1;
          end
        end
        DRAIN: if (rd.rd_ready) begin
          if (rd.rd_last) begin
            state       <= IDLE;
            done        <= 1'b1;
            rd.rd_valid <= 1'b0;
            rd.rd_last  <= 1'b0;
          end else begin
            idx        <= nidx;
            rd.rd_data <= cur[nidx*RD_W +: RD_W];
            rd.rd_last <= nidx == IW'(NW - 1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
